pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_if.sv | 40 ++++
 rtl/pipeline_ctrl.sv | 135 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline datapath and its hazard/stall controller.
// The master drives hazard and miss status; the slave (controller) returns stage enables.
interface pipeline_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             ID_EX_MemRead;
   logic [3:0]       ID_EX_RegRd;
   logic [3:0]       IF_ID_RegRs;
   logic [3:0]       IF_ID_RegRt;
   logic             IF_ID_UsesRt;
   logic             Branch_Taken;
   logic             Halt_ID;
   logic             IF_Miss;
   logic             MEM_Miss;
   logic             Mem_Done;
   logic             Stall_Count_Clr;
   logic             PC_Write;
   logic             IF_ID_Write;
   logic             IF_ID_Flush;
   logic             ID_EX_Bubble;
   logic             Pipe_Hold;
   logic             Mem_Sel;
   logic             Halted;
   logic [CNT_W-1:0] Stall_Count;
   logic [2:0]       State;

   modport master (
      output ID_EX_MemRead, ID_EX_RegRd, IF_ID_RegRs, IF_ID_RegRt, IF_ID_UsesRt,
             Branch_Taken, Halt_ID, IF_Miss, MEM_Miss, Mem_Done, Stall_Count_Clr,
      input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Hold, Mem_Sel,
             Halted, Stall_Count, State
   );

   modport slave (
      input  ID_EX_MemRead, ID_EX_RegRd, IF_ID_RegRs, IF_ID_RegRt, IF_ID_UsesRt,
             Branch_Taken, Halt_ID, IF_Miss, MEM_Miss, Mem_Done, Stall_Count_Clr,
      output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Hold, Mem_Sel,
             Halted, Stall_Count, State
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, I/D miss arbitration of the shared
// memory port, halt draining, and a saturating stalled-cycle counter.
module pipeline_ctrl #(
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 16
) (
   input  logic           clk,
   input  logic           rst,
   pipeline_ctrl_if.slave bus
);
   localparam logic [2:0] RUN    = 3'd0;
   localparam logic [2:0] IMISS  = 3'd2;
   localparam logic [2:0] DMISS  = 3'd3;
   localparam logic [2:0] DRAIN  = 3'd4;
   localparam logic [2:0] HALTED = 3'd5;
   localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

   logic [2:0]       state_reg, state_next;
   logic [2:0]       drain_reg, drain_next;
   logic             pending_reg, pending_next;
   logic [CNT_W-1:0] count_reg;
   logic             lu;
   logic             pc_write, if_id_write, if_id_flush, id_ex_bubble;
   logic             pipe_hold, mem_sel, halted;

   assign lu = bus.ID_EX_MemRead && (bus.ID_EX_RegRd != 4'd0) &&
               ((bus.ID_EX_RegRd == bus.IF_ID_RegRs) ||
                (bus.IF_ID_UsesRt && (bus.ID_EX_RegRd == bus.IF_ID_RegRt)));

   always_comb begin
      state_next   = state_reg;
      drain_next   = drain_reg;
      pending_next = 1'b0;
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      pipe_hold    = 1'b0;
      mem_sel      = 1'b0;
      halted       = 1'b0;
      case (state_reg)
         RUN: begin
            if (bus.MEM_Miss) begin
               pipe_hold  = 1'b1;
               mem_sel    = 1'b1;
               state_next = DMISS;
            end else if (bus.IF_Miss) begin
               if_id_flush = 1'b1;
               if_id_write = 1'b1;
               state_next  = IMISS;
            end else if (lu) begin
               id_ex_bubble = 1'b1;
            end else if (bus.Halt_ID) begin
               if_id_flush = 1'b1;
               if_id_write = 1'b1;
               drain_next  = DRAIN_LOAD;
               state_next  = DRAIN;
            end else if (bus.Branch_Taken) begin
               pc_write    = 1'b1;
               if_id_write = 1'b1;
               if_id_flush = 1'b1;
            end else begin
               pc_write    = 1'b1;
               if_id_write = 1'b1;
            end
         end
         IMISS: begin
            // A data miss during an instruction miss freezes the back end and is
            // remembered so it is serviced before fetch resumes.
            if_id_flush  = 1'b1;
            if_id_write  = !bus.MEM_Miss;
            pipe_hold    = bus.MEM_Miss;
            pending_next = pending_reg | bus.MEM_Miss;
            if (bus.Mem_Done) begin
               state_next   = (pending_reg || bus.MEM_Miss) ? DMISS : RUN;
               pending_next = 1'b0;
            end
         end
         DMISS: begin
            pipe_hold = 1'b1;
            mem_sel   = 1'b1;
            if (bus.Mem_Done) begin
               state_next = RUN;
            end
         end
         DRAIN: begin
            if_id_flush = 1'b1;
            if (bus.MEM_Miss) begin
               pipe_hold = 1'b1;
               mem_sel   = 1'b1;
            end else begin
               if_id_write = 1'b1;
               if (drain_reg == 3'd0) begin
                  state_next = HALTED;
               end else begin
                  drain_next = drain_reg - 3'd1;
               end
            end
         end
         HALTED: begin
            pipe_hold = 1'b1;
            halted    = 1'b1;
         end
         default: state_next = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= RUN;
         drain_reg   <= 3'd0;
         pending_reg <= 1'b0;
         count_reg   <= '0;
      end else begin
         state_reg   <= state_next;
         drain_reg   <= drain_next;
         pending_reg <= pending_next;
         if (bus.Stall_Count_Clr) begin
            count_reg <= '0;
         end else if (!pc_write && (state_reg != HALTED) && (count_reg != '1)) begin
            count_reg <= count_reg + CNT_W'(1);
         end
      end
   end

   assign bus.PC_Write     = pc_write;
   assign bus.IF_ID_Write  = if_id_write;
   assign bus.IF_ID_Flush  = if_id_flush;
   assign bus.ID_EX_Bubble = id_ex_bubble;
   assign bus.Pipe_Hold    = pipe_hold;
   assign bus.Mem_Sel      = mem_sel;
   assign bus.Halted       = halted;
   assign bus.Stall_Count  = count_reg;
   assign bus.State        = state_reg;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: two instances (default and CNT_W=4/DRAIN_CYCLES=1) share stimulus
// and are compared every cycle against a mode-level reference model, plus literal expectations.
`timescale 1ns/1ps
module tb_pipeline_ctrl;
   localparam int DC_A = 3;
   localparam int CW_A = 16;
   localparam int DC_B = 1;
   localparam int CW_B = 4;

   typedef struct packed {
      logic       memread;
      logic [3:0] rd;
      logic [3:0] rs;
      logic [3:0] rt;
      logic       uses_rt;
      logic       branch;
      logic       halt;
      logic       if_miss;
      logic       mem_miss;
      logic       mem_done;
      logic       clr;
   } in_t;

   typedef enum int {M_RUN, M_IMISS, M_DMISS, M_DRAIN, M_HALT} mode_e;

   typedef struct {
      mode_e mode;
      int    drain_left;
      bit    pending;
      int    count;
   } model_t;

   typedef struct {
      logic       pc, w, w_care, flush, bubble, hold, sel, sel_care, halted;
      logic [2:0] state;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic cmp_on = 1'b0;
   in_t  cur;
   int   checks = 0;
   int   errors = 0;
   model_t ma, mb;
   logic [9:0] out_a, out_b;

   always #5 clk = ~clk;

   pipeline_ctrl_if #(.CNT_W(CW_A)) bus_a ();
   pipeline_ctrl_if #(.CNT_W(CW_B)) bus_b ();

   pipeline_ctrl #(.DRAIN_CYCLES(DC_A), .CNT_W(CW_A)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   pipeline_ctrl #(.DRAIN_CYCLES(DC_B), .CNT_W(CW_B)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   assign bus_a.ID_EX_MemRead   = cur.memread;
   assign bus_a.ID_EX_RegRd     = cur.rd;
   assign bus_a.IF_ID_RegRs     = cur.rs;
   assign bus_a.IF_ID_RegRt     = cur.rt;
   assign bus_a.IF_ID_UsesRt    = cur.uses_rt;
   assign bus_a.Branch_Taken    = cur.branch;
   assign bus_a.Halt_ID         = cur.halt;
   assign bus_a.IF_Miss         = cur.if_miss;
   assign bus_a.MEM_Miss        = cur.mem_miss;
   assign bus_a.Mem_Done        = cur.mem_done;
   assign bus_a.Stall_Count_Clr = cur.clr;
   assign bus_b.ID_EX_MemRead   = cur.memread;
   assign bus_b.ID_EX_RegRd     = cur.rd;
   assign bus_b.IF_ID_RegRs     = cur.rs;
   assign bus_b.IF_ID_RegRt     = cur.rt;
   assign bus_b.IF_ID_UsesRt    = cur.uses_rt;
   assign bus_b.Branch_Taken    = cur.branch;
   assign bus_b.Halt_ID         = cur.halt;
   assign bus_b.IF_Miss         = cur.if_miss;
   assign bus_b.MEM_Miss        = cur.mem_miss;
   assign bus_b.Mem_Done        = cur.mem_done;
   assign bus_b.Stall_Count_Clr = cur.clr;

   // Packed view: {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Hold, Mem_Sel, Halted, State}
   assign out_a = {bus_a.PC_Write, bus_a.IF_ID_Write, bus_a.IF_ID_Flush, bus_a.ID_EX_Bubble,
                   bus_a.Pipe_Hold, bus_a.Mem_Sel, bus_a.Halted, bus_a.State};
   assign out_b = {bus_b.PC_Write, bus_b.IF_ID_Write, bus_b.IF_ID_Flush, bus_b.ID_EX_Bubble,
                   bus_b.Pipe_Hold, bus_b.Mem_Sel, bus_b.Halted, bus_b.State};

   function automatic bit load_use(input in_t i);
      return i.memread && (i.rd != 4'd0) &&
             ((i.rd == i.rs) || (i.uses_rt && (i.rd == i.rt)));
   endfunction

   function automatic exp_t predict(input model_t m, input in_t i);
      exp_t e;
      e = '{default: '0};
      e.w_care   = 1'b1;
      e.sel_care = 1'b1;
      case (m.mode)
         M_RUN: begin
            e.state = 3'd0;
            if (i.mem_miss) begin
               e.hold = 1'b1; e.sel = 1'b1;
            end else if (i.if_miss) begin
               e.flush = 1'b1; e.w_care = 1'b0;
            end else if (load_use(i)) begin
               e.bubble = 1'b1;
            end else if (i.halt) begin
               e.flush = 1'b1; e.w_care = 1'b0;
            end else if (i.branch) begin
               e.pc = 1'b1; e.flush = 1'b1; e.w_care = 1'b0;
            end else begin
               e.pc = 1'b1; e.w = 1'b1;
            end
         end
         M_IMISS: begin
            e.state = 3'd2; e.flush = 1'b1; e.hold = i.mem_miss; e.w_care = i.mem_miss;
         end
         M_DMISS: begin
            e.state = 3'd3; e.hold = 1'b1; e.sel = 1'b1;
         end
         M_DRAIN: begin
            e.state = 3'd4; e.flush = 1'b1; e.hold = i.mem_miss;
            e.w_care = 1'b0; e.sel_care = 1'b0;
         end
         default: begin
            e.state = 3'd5; e.hold = 1'b1; e.halted = 1'b1; e.sel_care = 1'b0;
         end
      endcase
      return e;
   endfunction

   // drain_left counts the DRAIN cycles still to be spent, rather than a down-counter value.
   function automatic model_t advance(input model_t m, input in_t i, input int dc, input int cmax);
      model_t n;
      exp_t   e;
      n = m;
      e = predict(m, i);
      if (i.clr) n.count = 0;
      else if (!e.pc && m.mode != M_HALT && m.count < cmax) n.count = m.count + 1;
      case (m.mode)
         M_RUN: begin
            if (i.mem_miss) n.mode = M_DMISS;
            else if (i.if_miss) n.mode = M_IMISS;
            else if (!load_use(i) && i.halt) begin
               n.mode = M_DRAIN;
               n.drain_left = dc;
            end
         end
         M_IMISS: begin
            if (i.mem_miss) n.pending = 1'b1;
            if (i.mem_done) begin
               n.mode = (m.pending || i.mem_miss) ? M_DMISS : M_RUN;
               n.pending = 1'b0;
            end
         end
         M_DMISS: if (i.mem_done) n.mode = M_RUN;
         M_DRAIN: begin
            if (!i.mem_miss) begin
               n.drain_left = m.drain_left - 1;
               if (n.drain_left == 0) n.mode = M_HALT;
            end
         end
         default: ;
      endcase
      return n;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ma <= '{M_RUN, 0, 1'b0, 0};
         mb <= '{M_RUN, 0, 1'b0, 0};
      end else begin
         ma <= advance(ma, cur, DC_A, (1 << CW_A) - 1);
         mb <= advance(mb, cur, DC_B, (1 << CW_B) - 1);
      end
   end

   task automatic cmp_model(input string name, input logic [9:0] act, input int act_cnt,
                            input model_t m);
      exp_t e;
      logic [9:0] ev, mask;
      e    = predict(m, cur);
      ev   = {e.pc, e.w, e.flush, e.bubble, e.hold, e.sel, e.halted, e.state};
      mask = {1'b1, e.w_care, 3'b111, e.sel_care, 4'b1111};
      checks++;
      if ((act & mask) !== (ev & mask)) begin
         errors++;
         $display("FAIL %s_outputs t=%0t got %b expected %b (mask %b)", name, $time, act, ev, mask);
      end
      checks++;
      if (act_cnt != m.count) begin
         errors++;
         $display("FAIL %s_stall_count t=%0t got %0d expected %0d", name, $time, act_cnt, m.count);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_on && !rst) begin
         cmp_model("model_a", out_a, int'(bus_a.Stall_Count), ma);
         cmp_model("model_b", out_b, int'(bus_b.Stall_Count), mb);
      end
   end

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp_v);
      end
   endtask

   task automatic tick(input in_t v);
      @(posedge clk);
      #1;
      cur = v;
   endtask

   task automatic see();
      @(negedge clk);
      #1;
      $display("t=%0t state_a=%0d out_a=%b cnt_a=%0d state_b=%0d cnt_b=%0d",
               $time, out_a[2:0], out_a, bus_a.Stall_Count, out_b[2:0], bus_b.Stall_Count);
   endtask

   task automatic async_reset();
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("async_state_a", int'(out_a[2:0]), 0);
      chk("async_count_a", int'(bus_a.Stall_Count), 0);
      chk("async_state_b", int'(out_b[2:0]), 0);
      #1;
      rst = 1'b0;
      $display("t=%0t async reset pulse", $time);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog t=%0t bench did not finish", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      in_t v;
      cur = '0;
      #1 rst = 1'b1;
      #10;
      chk("reset_hold_state", int'(out_a[2:0]), 0);
      chk("reset_hold_count", int'(bus_a.Stall_Count), 0);
      rst = 1'b0;
      cmp_on = 1'b1;

      see();
      chk("reset_outputs", int'(out_a), 10'h300);

      // Load r3 in EX, ID reads r3
      v = '0; v.memread = 1'b1; v.rd = 4'd3; v.rs = 4'd3;
      tick(v); see();
      chk("lu_bubble", int'(out_a[6]), 1);
      chk("lu_pc_write", int'(out_a[9]), 0);
      v = '0;
      tick(v); see();
      chk("lu_count", int'(bus_a.Stall_Count), 1);
      v = '0; v.memread = 1'b1; v.rd = 4'd0; v.rs = 4'd0;
      tick(v); see();
      chk("r0_no_bubble", int'(out_a[6]), 0);
      chk("r0_pc_write", int'(out_a[9]), 1);

      // Simultaneous data and instruction miss
      v = '0; v.mem_miss = 1'b1; v.if_miss = 1'b1;
      tick(v); see();
      chk("dual_miss_run_sel", int'(out_a[4]), 1);
      for (int k = 0; k < 4; k++) begin
         tick(v); see();
         chk("dual_miss_dmiss", int'(out_a[2:0]), 3);
      end
      v.mem_miss = 1'b0; v.mem_done = 1'b1;
      tick(v); see();
      chk("dual_miss_dmiss_last", int'(out_a[2:0]), 3);
      chk("dual_miss_dmiss_sel", int'(out_a[4]), 1);
      v = '0; v.if_miss = 1'b1;
      tick(v); see();
      chk("dual_miss_back_run", int'(out_a[2:0]), 0);
      tick(v); see();
      chk("dual_miss_imiss", int'(out_a[2:0]), 2);
      chk("dual_miss_imiss_sel", int'(out_a[4]), 0);
      v.mem_done = 1'b1;
      tick(v); see();
      v = '0;
      tick(v); see();
      chk("dual_miss_done_run", int'(out_a[2:0]), 0);

      // Data miss arriving during an instruction miss
      v = '0; v.if_miss = 1'b1;
      tick(v); see();
      tick(v); see();
      chk("imiss_enter", int'(out_a[2:0]), 2);
      v.mem_miss = 1'b1;
      tick(v); see();
      chk("imiss_dmiss_hold", int'(out_a[5]), 1);
      v = '0; v.mem_done = 1'b1;
      tick(v); see();
      chk("imiss_done_state", int'(out_a[2:0]), 2);
      v = '0;
      tick(v); see();
      chk("pending_to_dmiss", int'(out_a[2:0]), 3);
      v.mem_done = 1'b1;
      tick(v); see();
      v = '0;
      tick(v); see();
      chk("pending_back_run", int'(out_a[2:0]), 0);

      // Load-use and branch in the same cycle
      v = '0; v.memread = 1'b1; v.rd = 4'd5; v.rt = 4'd5; v.uses_rt = 1'b1; v.branch = 1'b1;
      tick(v); see();
      chk("lu_branch_flush", int'(out_a[7]), 0);
      chk("lu_branch_bubble", int'(out_a[6]), 1);
      v.memread = 1'b0;
      tick(v); see();
      chk("branch_next_flush", int'(out_a[7]), 1);
      chk("branch_next_pc", int'(out_a[9]), 1);

      // Randomized phase with occasional halts and asynchronous resets
      for (int n = 0; n < 400; n++) begin
         v.memread  = ($urandom_range(0, 2) == 0);
         v.rd       = 4'($urandom_range(0, 4));
         v.rs       = 4'($urandom_range(0, 4));
         v.rt       = 4'($urandom_range(0, 4));
         v.uses_rt  = 1'($urandom_range(0, 1));
         v.branch   = ($urandom_range(0, 3) == 0);
         v.halt     = ($urandom_range(0, 39) == 0);
         v.if_miss  = ($urandom_range(0, 5) == 0);
         v.mem_miss = ($urandom_range(0, 5) == 0);
         v.mem_done = ($urandom_range(0, 3) == 0);
         v.clr      = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 39) == 0) async_reset();
         else tick(v);
      end

      // Stall counter saturation on the 4-bit instance, clear beats increment
      v = '0;
      tick(v);
      async_reset();
      v.memread = 1'b1; v.rd = 4'd1; v.rs = 4'd1;
      for (int k = 0; k < 20; k++) tick(v);
      v.clr = 1'b1;
      tick(v); see();
      chk("sat_count_b", int'(bus_b.Stall_Count), 15);
      chk("count_a_20", int'(bus_a.Stall_Count), 20);
      v = '0;
      tick(v); see();
      chk("clr_count_b", int'(bus_b.Stall_Count), 0);
      chk("clr_count_a", int'(bus_a.Stall_Count), 0);

      // Halt with no misses: three drain cycles on A, then permanently halted
      tick(v);
      async_reset();
      v.halt = 1'b1;
      tick(v); see();
      chk("halt_run_flush", int'(out_a[7]), 1);
      chk("halt_run_pc", int'(out_a[9]), 0);
      v = '0;
      for (int k = 0; k < 3; k++) begin
         tick(v); see();
         chk("halt_drain_state", int'(out_a[2:0]), 4);
      end
      for (int k = 0; k < 4; k++) begin
         tick(v); see();
         chk("halted_state", int'(out_a[2:0]), 5);
         chk("halted_flag", int'(out_a[3]), 1);
         chk("halted_count_a", int'(bus_a.Stall_Count), 4);
         chk("halted_count_b", int'(bus_b.Stall_Count), 2);
      end

      cmp_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
